// File: rtl/abcd_expr_pkg.sv
// Shared types and the saturate/wrap helper for the abcd expression pipe.
package abcd_expr_pkg;

  // Widest intermediate the helper accepts; callers sign-extend into this.
  localparam int SAT_MAX_W = 128;

  // Per-transaction mode bits carried alongside the data through the pipe.
  typedef struct packed {
    logic sat_en;
    logic rnd_en;
  } mode_t;

  // Helper result: overflow flag plus a value that is always representable
  // in the requested width (sign-extended to SAT_MAX_W bits).
  typedef struct packed {
    logic                 ovf;
    logic [SAT_MAX_W-1:0] value;
  } sat_res_t;

  // Clamp (sat_en=1) or wrap to the low dw bits (sat_en=0); ovf reports
  // whether the input fits dw bits signed, independent of the mode.
  function automatic sat_res_t sat_trunc(
    input logic signed [SAT_MAX_W-1:0] value,
    input logic                        sat_en,
    input int                          dw
  );
    logic        [SAT_MAX_W-1:0] one_v;
    logic signed [SAT_MAX_W-1:0] max_v;
    logic signed [SAT_MAX_W-1:0] min_v;
    sat_res_t                    res;
    one_v   = {{(SAT_MAX_W-1){1'b0}}, 1'b1};
    max_v   = $signed((one_v << (dw - 1)) - one_v);
    min_v   = ~max_v;
    res.ovf = (value > max_v) || (value < min_v);
    if (!sat_en) begin
      res.value = (value <<< (SAT_MAX_W - dw)) >>> (SAT_MAX_W - dw);
    end else if (value > max_v) begin
      res.value = max_v;
    end else if (value < min_v) begin
      res.value = min_v;
    end else begin
      res.value = value;
    end
    return res;
  endfunction

endpackage

// File: rtl/abcd_expr_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
module abcd_expr_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_push  = push_i & ~w_full;
  assign w_pop   = pop_i & (r_count != '0);
  assign data_o  = r_mem[r_rd_ptr];
  assign valid_o = (r_count != '0);
  assign count_o = r_count;

  // Storage; cleared on reset so the head reads 0 while empty after reset
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // Occupancy tracks simultaneous push and pop as no change
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  abcd_expr_fifo_chk u_chk (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .push_i (push_i),
    .full_i (w_full)
  );

endmodule

// File: rtl/abcd_expr_fifo_chk.sv
// Checker: the output FIFO must never see a write while it is full.
module abcd_expr_fifo_chk (
  input logic clk_i,
  input logic arst_i,
  input logic push_i,
  input logic full_i
);

  a_no_push_when_full: assert property (
    @(posedge clk_i) disable iff (arst_i) !(push_i && full_i)
  );

endmodule

// File: rtl/abcd_expr_sat_chk.sv
// Checker: the saturate/wrap helper must hand back a value that fits DW bits.
module abcd_expr_sat_chk #(
  parameter int W  = 128,
  parameter int DW = 16
) (
  input logic         clk_i,
  input logic         arst_i,
  input logic         valid_i,
  input logic [W-1:0] value_i
);

  a_result_fits: assert property (
    @(posedge clk_i) disable iff (arst_i)
      !valid_i || (&value_i[W-1:DW-1]) || !(|value_i[W-1:DW-1])
  );

endmodule

// File: rtl/abcd_expr_pipe.sv
// Streaming evaluator q = round_shift((a-b)*(K_C*c+K_0) - K_D*d) with
// per-operand joins, credit-gated issue and an output FWFT FIFO.
module abcd_expr_pipe
  import abcd_expr_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int K_WIDTH    = 8,
  parameter int SHIFT      = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         arst_i,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  input  logic signed [DATA_WIDTH-1:0] c_i,
  input  logic signed [DATA_WIDTH-1:0] d_i,
  input  logic                         a_valid_i,
  input  logic                         b_valid_i,
  input  logic                         c_valid_i,
  input  logic                         d_valid_i,
  output logic                         a_ready_o,
  output logic                         b_ready_o,
  output logic                         c_ready_o,
  output logic                         d_ready_o,
  input  logic signed [K_WIDTH-1:0]    k_c_i,
  input  logic signed [K_WIDTH-1:0]    k_0_i,
  input  logic signed [K_WIDTH-1:0]    k_d_i,
  input  logic                         sat_en_i,
  input  logic                         rnd_en_i,
  output logic signed [DATA_WIDTH-1:0] q_o,
  output logic                         q_valid_o,
  input  logic                         q_ready_i,
  output logic                         ovf_o,
  input  logic                         ovf_clr_i
);

  localparam int DIFF_W = DATA_WIDTH + 1;
  localparam int CT_W   = DATA_WIDTH + K_WIDTH + 1;
  localparam int DT_W   = DATA_WIDTH + K_WIDTH;
  localparam int PROD_W = DIFF_W + CT_W;
  localparam int SUM_W  = 2 * DATA_WIDTH + K_WIDTH + 3;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  // One extra bit so count + inflight cannot wrap for FIFO_DEPTH = 2
  localparam int CRED_W = CNT_W + 1;
  localparam logic signed [SUM_W-1:0] RND_C =
    SUM_W'(2 ** ((SHIFT > 0) ? (SHIFT - 1) : 0));

  // Join stage; bit order is {d, c, b, a}
  logic signed [DATA_WIDTH-1:0] r_a, r_b, r_c, r_d;
  logic [3:0]                   r_held;
  logic [3:0]                   w_valid;
  logic [3:0]                   w_ready;
  logic [3:0]                   w_acc;
  logic                         w_fire;
  logic [CNT_W-1:0]             w_fifo_count;
  logic [CRED_W-1:0]            w_used;

  // Pipe stages
  logic                     r_s1_v;
  logic signed [DIFF_W-1:0] r_s1_diff;
  logic signed [CT_W-1:0]   r_s1_ct;
  logic signed [DT_W-1:0]   r_s1_dt;
  mode_t                    r_s1_mode;
  logic                     r_s2_v;
  logic signed [PROD_W-1:0] r_s2_prod;
  logic signed [DT_W-1:0]   r_s2_dt;
  mode_t                    r_s2_mode;

  logic signed [DIFF_W-1:0] w_diff;
  logic signed [CT_W-1:0]   w_ct;
  logic signed [DT_W-1:0]   w_dt;
  logic signed [SUM_W-1:0]  w_rnd;
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [SUM_W-1:0]  w_shift;
  sat_res_t                 w_sat;
  logic [DATA_WIDTH-1:0]    w_q;
  logic                     w_pop;
  logic                     r_ovf;

  assign w_valid = {d_valid_i, c_valid_i, b_valid_i, a_valid_i};
  // Credits: FIFO entries plus results already committed to S1/S2
  assign w_used  = CRED_W'(w_fifo_count) + CRED_W'(r_s1_v) + CRED_W'(r_s2_v);
  assign w_fire  = (&r_held) & (w_used < CRED_W'(FIFO_DEPTH));
  // Ready depends only on state, never on the valids; held low in reset
  assign w_ready = {4{~arst_i}} & (~r_held | {4{w_fire}});
  assign w_acc   = w_valid & w_ready;

  assign a_ready_o = w_ready[0];
  assign b_ready_o = w_ready[1];
  assign c_ready_o = w_ready[2];
  assign d_ready_o = w_ready[3];

  // Held flags: accept sets, fire clears unless refilled in the same cycle
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_held <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_acc[i])    r_held[i] <= 1'b1;
        else if (w_fire) r_held[i] <= 1'b0;
      end
    end
  end

  // Operand hold registers, written only on accept
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
      r_d <= '0;
    end else begin
      if (w_acc[0]) r_a <= a_i;
      if (w_acc[1]) r_b <= b_i;
      if (w_acc[2]) r_c <= c_i;
      if (w_acc[3]) r_d <= d_i;
    end
  end

  assign w_diff = DIFF_W'(r_a) - DIFF_W'(r_b);
  assign w_ct   = CT_W'(k_c_i) * CT_W'(r_c) + CT_W'(k_0_i);
  assign w_dt   = DT_W'(k_d_i) * DT_W'(r_d);

  // S1: difference and both coefficient terms, captured at fire
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_s1_v    <= 1'b0;
      r_s1_diff <= '0;
      r_s1_ct   <= '0;
      r_s1_dt   <= '0;
      r_s1_mode <= '0;
    end else begin
      r_s1_v <= w_fire;
      if (w_fire) begin
        r_s1_diff <= w_diff;
        r_s1_ct   <= w_ct;
        r_s1_dt   <= w_dt;
        r_s1_mode <= {sat_en_i, rnd_en_i};
      end
    end
  end

  // S2: full-width product
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_s2_v    <= 1'b0;
      r_s2_prod <= '0;
      r_s2_dt   <= '0;
      r_s2_mode <= '0;
    end else begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_prod <= PROD_W'(r_s1_diff) * PROD_W'(r_s1_ct);
        r_s2_dt   <= r_s1_dt;
        r_s2_mode <= r_s1_mode;
      end
    end
  end

  // S3: subtract, optional round, shift and saturate/wrap into the FIFO
  always_comb begin
    w_rnd = '0;
    if (r_s2_mode.rnd_en && (SHIFT > 0)) begin
      w_rnd = RND_C;
    end else begin
      w_rnd = '0;
    end
    w_sum   = SUM_W'(r_s2_prod) - SUM_W'(r_s2_dt) + w_rnd;
    w_shift = w_sum >>> SHIFT;
    w_sat   = sat_trunc(SAT_MAX_W'(w_shift), r_s2_mode.sat_en, DATA_WIDTH);
    w_q     = w_sat.value[DATA_WIDTH-1:0];
  end

  assign w_pop = q_valid_o & q_ready_i;

  abcd_expr_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .push_i  (r_s2_v),
    .data_i  (w_q),
    .pop_i   (w_pop),
    .data_o  (q_o),
    .valid_o (q_valid_o),
    .count_o (w_fifo_count)
  );

  // Sticky overflow; a new event in the clear cycle keeps the flag set
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_ovf <= 1'b0;
    end else if (r_s2_v && w_sat.ovf) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr_i) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf_o = r_ovf;

  abcd_expr_sat_chk #(
    .W  (SAT_MAX_W),
    .DW (DATA_WIDTH)
  ) u_sat_chk (
    .clk_i   (clk_i),
    .arst_i  (arst_i),
    .valid_i (r_s2_v),
    .value_i (w_sat.value)
  );

endmodule

// File: doc/abcd_expr_pipe.md
# abcd_expr_pipe

Parametrised streaming evaluator of q = round_shift((a − b)·(K_C·c + K_0) − K_D·d) with runtime coefficients, selectable saturation and rounding, per-operand valid/ready joins, and a credit-protected output FIFO. It sits where the fixed-function (a−b)(3c+1)−4d)/2 pipe sits in the datapath. Downstream may now apply backpressure, operands may arrive on different cycles without loss, and widths/shift are generic.

## Interface
- DATA_WIDTH, 16: operand and result width (signed).
- K_WIDTH, 8: coefficient width (signed).
- SHIFT, 1: arithmetic right shift applied to the sum (0..DATA_WIDTH−1).
- FIFO_DEPTH, 4: output FIFO entries (power of two, ≥2).
- clk_i  in  1  clock.
- arst_i  in  1  reset; asynchronous, active-high.
- a_i/b_i/c_i/d_i  in  DATA_WIDTH each  signed operands.
- a_valid_i/b_valid_i/c_valid_i/d_valid_i  in  1 each  operand valid.
- a_ready_o/b_ready_o/c_ready_o/d_ready_o  out  1 each  operand ready.
- k_c_i, k_0_i, k_d_i  in  K_WIDTH each  signed coefficients, sampled at fire.
- sat_en_i  in  1  1 = saturate, 0 = wrap (truncate), sampled at fire.
- rnd_en_i  in  1  1 = round half up before shift, sampled at fire.
- q_o  out  DATA_WIDTH  signed result (FIFO head).
- q_valid_o  out  1  FIFO non-empty.
- q_ready_i  in  1  downstream accept.
- ovf_o  out  1  sticky overflow flag.
- ovf_clr_i  in  1  clear ovf_o.

## Operation
- Join stage: one hold register and held flag per operand. x accepted when x_valid_i & x_ready_o; x_ready_o = ~held_x | fire.
- fire = all four held & (fifo_count + inflight) < FIFO_DEPTH, where inflight = number of valid S1/S2 entries. Pop in the same cycle does not add credit.
- On fire: held flags clear, unless the same operand is accepted that cycle. Operands, coefficients, sat_en and rnd_en load into S1.
- S1: diff = a−b (DATA_WIDTH+1); ct = K_C·c + K_0 (DATA_WIDTH+K_WIDTH+1); dt = K_D·d (DATA_WIDTH+K_WIDTH).
- S2: prod = diff·ct at full width.
- S3 (combinational into FIFO write): sum = prod − dt, SUM_W = 2·DATA_WIDTH+K_WIDTH+3.
  - If rnd_en and SHIFT>0, add 2^(SHIFT−1) first.
  - Arithmetic shift by SHIFT.
  - Saturate to [−2^(DW−1), 2^(DW−1)−1] if sat_en, else keep the low DATA_WIDTH bits.
  - overflow event = the shifted value does not fit DATA_WIDTH, in either mode.
- FIFO: first-word-fall-through. Pop on q_valid_o & q_ready_i. Order is preserved. Push when full cannot occur by construction; an assertion checks this.
- ovf_o is set by an overflow event at FIFO write and cleared by ovf_clr_i. If both occur in the same cycle, set wins.

## Timing
- Reset values:
  - all held flags, S1/S2 valids, FIFO pointers and ovf_o are 0.
  - q_o = 0 and q_valid_o = 0.
  - x_ready_o = 0 while arst_i is high, then 1 from the first cycle after release.
- Latency: all operands presented in cycle 0 with an empty FIFO gives accept at edge 1, S1 at edge 2, S2 at edge 3, FIFO write at edge 4, and q_valid_o high in cycle 4.
- Throughput: one result per cycle with q_ready_i held high, given FIFO_DEPTH ≥ 4. Smaller depths throttle fire.
- Held operands stay stable regardless of other channels. No operand is dropped or duplicated.
- Reset mid-operation: held, in-flight and FIFO contents are discarded. No stale result appears after release.

## Structure
- Package abcd_expr_pkg holds:
  - typedef struct mode_t {sat_en, rnd_en}, carried through the pipe;
  - function sat_trunc(value, sat_en) returning the result and an overflow bit.
- Width localparams depend on the module parameters and stay in the module.
- One sub-module: abcd_expr_fifo, a parametrised FWFT sync FIFO with count output and asynchronous active-high reset.

## Test plan
All scenarios use DATA_WIDTH=16, SHIFT=1, K_C=3, K_0=1, K_D=4 unless stated otherwise.
- All operands together: a=10, b=4, c=2, d=3, q_ready high -> q_o=15 with q_valid_o in cycle 4. ovf_o stays 0.
- Staggered operands: a in cycle 0, b in cycle 2, c and d in cycle 5 -> a_ready_o low cycles 1–5, fire in cycle 6, q_o=15 in cycle 9.
- Saturation and wrap: a=32767, b=−32768, c=100, d=0.
  - sat_en=1 -> q_o=32767, ovf_o=1.
  - sat_en=0 -> q_o=32617, ovf_o=1.
  - ovf_clr_i pulse -> ovf_o=0.
- Rounding:
  - a=1, b=0, c=0, d=0 -> q_o=0 with rnd_en=0, q_o=1 with rnd_en=1.
  - a=0, b=1 -> q_o=−1 with rnd_en=0, q_o=0 with rnd_en=1.
- Backpressure: 10 back-to-back vectors with q_ready_i low -> readies drop once credits are exhausted. After q_ready_i rises, all 10 results emerge in order with no loss or duplication.
- Reset mid-stream: arst_i pulses with 3 results in flight -> q_valid_o=0 the cycle after assertion, and no stale results after release.
